// File: rtl/k007232_pkg.sv
// Shared constants and types for the 007232 volume mixer stage.
// Sample and volume widths, FSM state enum, bias-removal helper.
package k007232_pkg;

  localparam int SAMPLE_W    = 7;
  localparam int VOL_W       = 4;
  localparam int SAMPLE_BIAS = 64;
  localparam int PROD_W      = 11;
  localparam int SUM_W       = 12;
  localparam int SMP_S_W     = SAMPLE_W + 1;
  localparam int STEP_W      = $clog2(VOL_W);

  typedef enum logic [1:0] {
    IDLE,
    MUL_A,
    MUL_B,
    SUM
  } mix_state_t;

  function automatic logic signed [SMP_S_W-1:0] unbias(
    input logic [SAMPLE_W-1:0] s
  );
    return SMP_S_W'({1'b0, s}) - SMP_S_W'(SAMPLE_BIAS);
  endfunction

endpackage

// File: rtl/k007232_shift_mul.sv
// Serial signed x unsigned shift-add multiplier, volume LSB first.
// The start cycle performs step 0; done marks the final step.
module k007232_shift_mul
  import k007232_pkg::*;
(
  input  logic                      i_EMUCLK,
  input  logic                      i_RST,
  input  logic                      start,
  input  logic signed [SMP_S_W-1:0] a,
  input  logic [VOL_W-1:0]          b,
  output logic signed [PROD_W-1:0]  prod,
  output logic                      run,
  output logic                      done
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] a_q;
  logic [VOL_W-1:0]         b_q;
  logic [STEP_W-1:0]        step;

  assign a_ext = PROD_W'(a);
  assign done  = run && (step == STEP_W'(VOL_W - 1));

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      run  <= 1'b0;
      step <= '0;
      prod <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (start) begin
      a_q  <= a_ext;
      b_q  <= b;
      prod <= b[0] ? a_ext : '0;
      step <= STEP_W'(1);
      run  <= 1'b1;
    end else if (run) begin
      if (b_q[step])
        prod <= prod + (a_q <<< step);
      step <= step + 1'b1;
      if (done)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/k007232_vol_mixer.sv
// 007232 volume latch, per-channel scaling and two-channel mix.
// Define K007232_VOLMIX_SAT_EN to clamp instead of wrap on overflow.
module k007232_vol_mixer
  import k007232_pkg::*;
#(
  parameter int OUT_W      = 16,
  parameter int GAIN_SHIFT = 4
) (
  input  logic                i_EMUCLK,
  input  logic                i_RST,
  input  logic                i_CEN,
  input  logic                i_SLEV_n,
  input  logic [7:0]          i_DB,
  input  logic [SAMPLE_W-1:0] i_ASD,
  input  logic [SAMPLE_W-1:0] i_BSD,
  output logic [VOL_W-1:0]    o_VOLA,
  output logic [VOL_W-1:0]    o_VOLB,
  output logic                o_BUSY,
  output logic [OUT_W-1:0]    o_SND,
  output logic                o_VALID
);

  localparam int SH_RAW = SUM_W + GAIN_SHIFT;
  localparam int SH_W   = (OUT_W > SH_RAW) ? OUT_W : SH_RAW;

  mix_state_t state, state_nx;

  logic signed [SMP_S_W-1:0] sa_q, sb_q;
  logic [VOL_W-1:0]          va_q, vb_q;
  logic signed [PROD_W-1:0]  pa_q;

  logic                      mul_start;
  logic signed [SMP_S_W-1:0] mul_a;
  logic [VOL_W-1:0]          mul_b;
  logic signed [PROD_W-1:0]  mul_prod;
  logic                      mul_run;
  logic                      mul_done;

  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SH_W-1:0]    sh_c;
  logic [OUT_W-1:0]          snd_c;

  k007232_shift_mul u_mul (
    .i_EMUCLK (i_EMUCLK),
    .i_RST    (i_RST),
    .start    (mul_start),
    .a        (mul_a),
    .b        (mul_b),
    .prod     (mul_prod),
    .run      (mul_run),
    .done     (mul_done)
  );

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      o_VOLA <= '0;
      o_VOLB <= '0;
    end else if (!i_SLEV_n) begin
      o_VOLA <= i_DB[7:4];
      o_VOLB <= i_DB[3:0];
    end
  end

  // Snapshot reads the volume registers before any same-edge write lands
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      sa_q <= '0;
      sb_q <= '0;
      va_q <= '0;
      vb_q <= '0;
    end else if (state == IDLE && i_CEN) begin
      sa_q <= unbias(i_ASD);
      sb_q <= unbias(i_BSD);
      va_q <= o_VOLA;
      vb_q <= o_VOLB;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    mul_a     = sa_q;
    mul_b     = va_q;
    unique case (state)
      IDLE: begin
        if (i_CEN)
          state_nx = MUL_A;
      end
      MUL_A: begin
        mul_start = !mul_run;
        if (mul_done)
          state_nx = MUL_B;
      end
      MUL_B: begin
        mul_start = !mul_run;
        mul_a     = sb_q;
        mul_b     = vb_q;
        if (mul_done)
          state_nx = SUM;
      end
      SUM: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Channel A product is still held in the multiplier as B starts
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST)
      pa_q <= '0;
    else if (state == MUL_B && mul_start)
      pa_q <= mul_prod;
  end

  assign sum_c = SUM_W'(pa_q) + SUM_W'(mul_prod);
  assign sh_c  = SH_W'(sum_c) <<< GAIN_SHIFT;

`ifdef K007232_VOLMIX_SAT_EN
  localparam logic signed [SH_W-1:0] SND_HI =
    {{(SH_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SH_W-1:0] SND_LO =
    {{(SH_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  always_comb begin
    snd_c = sh_c[OUT_W-1:0];
    if (sh_c > SND_HI)
      snd_c = SND_HI[OUT_W-1:0];
    else if (sh_c < SND_LO)
      snd_c = SND_LO[OUT_W-1:0];
  end
`else
  assign snd_c = sh_c[OUT_W-1:0];
`endif

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      o_SND   <= '0;
      o_VALID <= 1'b0;
    end else begin
      o_VALID <= (state == SUM);
      if (state == SUM)
        o_SND <= snd_c;
    end
  end

  assign o_BUSY = (state != IDLE);

endmodule

// File: doc/k007232_vol_mixer.md
Name: k007232_vol_mixer

Overview:
- Stage directly downstream of the 007232 PCM core.
- Latches the external volume byte written through the SLEV strobe (AAAABBBB).
- Consumes the per-channel 7-bit sample outputs (ASD/BSD), removes the 0x40 bias and scales each channel by its 4-bit volume using a serial shift-add multiplier.
- Sums both channels into one signed PCM word for the board mixer, with a one-cycle valid pulse.

Parameters:
- OUT_W, 16, width of signed output word.
- GAIN_SHIFT, 4, left shift applied to the 12-bit channel sum before output.

Ports:
- i_EMUCLK  in  1  master clock; all state on posedge.
- i_RST  in  1  synchronous active-high reset.
- i_CEN  in  1  sample tick; one-cycle pulse requests a new mix.
- i_SLEV_n  in  1  active-low volume latch strobe from 007232.
- i_DB  in  8  CPU data bus; [7:4]=ch A volume, [3:0]=ch B volume.
- i_ASD  in  7  ch A sample, unsigned, bias 0x40.
- i_BSD  in  7  ch B sample, unsigned, bias 0x40.
- o_VOLA  out  4  current latched ch A volume.
- o_VOLB  out  4  current latched ch B volume.
- o_BUSY  out  1  high while a mix is in progress.
- o_SND  out  OUT_W  signed mixed sample, held between updates.
- o_VALID  out  1  one-cycle pulse when o_SND updates.

Behaviour:
- Reset values: o_VOLA=0, o_VOLB=0, o_BUSY=0, o_SND=0, o_VALID=0, FSM=IDLE. Reset mid-mix aborts immediately; no o_VALID is produced.
- Volume latch:
  - Any posedge with i_SLEV_n=0 loads o_VOLA=i_DB[7:4] and o_VOLB=i_DB[3:0].
  - A strobe held low for several cycles reloads every cycle; the last value wins.
- Bias removal: sA = i_ASD - 64 and sB = i_BSD - 64, signed 8-bit, range -64..+63.
- Multiply:
  - Signed sample × unsigned volume gives an 11-bit signed product, range -960..+945.
  - Shift-add over 4 cycles per channel, LSB of volume first.
  - Volume 0 yields 0.
- FSM states IDLE, MUL_A, MUL_B, SUM:
  - IDLE: on i_CEN, snapshot sA, sB, o_VOLA, o_VOLB, then go to MUL_A. o_BUSY=1 from the next cycle.
  - MUL_A: 4 cycles, then MUL_B.
  - MUL_B: 4 cycles, then SUM.
  - SUM: 1 cycle. Computes 12-bit sum = pA + pB, shifts it left by GAIN_SHIFT, writes o_SND, pulses o_VALID, returns to IDLE. o_BUSY falls in the same cycle.
- Latency: i_CEN at cycle 0 gives o_VALID at cycle 10.
- Back-to-back ticks: minimum i_CEN spacing is 10 cycles.
  - i_CEN while o_BUSY=1 is dropped with no state change.
  - i_CEN coincident with SUM is also dropped.
- Snapshot rule: an SLEV write at the same edge as the accepted i_CEN, or during the mix, does not affect the current result. The snapshot takes the pre-write volume; the new volume applies from the next accepted tick.
- Width rule: the shifted sum is computed at max(OUT_W, 12+GAIN_SHIFT) bits, then reduced to OUT_W per the Optional Feature.

Optional Feature:
- Macro: K007232_VOLMIX_SAT_EN.
- Defined: if the shifted sum exceeds the OUT_W signed range, o_SND clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- Undefined: o_SND takes the low OUT_W bits of the shifted sum (two's-complement wrap).
- With the defaults no overflow is possible, so both builds give identical results.

Decomposition:
- Package k007232_pkg holds:
  - SAMPLE_W=7, VOL_W=4, SAMPLE_BIAS=64, PROD_W=11, SUM_W=12.
  - FSM state enum {IDLE, MUL_A, MUL_B, SUM}.
- One sub-module, k007232_shift_mul: 4-step serial signed(8) × unsigned(4) multiplier with start/done. It is instantiated once and reused for A then B.

Test Plan:
- Reset, then hold i_SLEV_n=1 and pulse i_CEN -> o_SND=0x0000 at cycle 10 (volumes are 0); o_VOLA=o_VOLB=0.
- SLEV write i_DB=0xF0; ASD=0x7F, BSD=0x00; i_CEN -> o_SND=0x3B10 (945<<4), o_VALID at cycle 10 only, o_BUSY high for cycles 1-9.
- SLEV write 0xFF; ASD=BSD=0x00 -> o_SND=0x8800 (-1920<<4); then SLEV write 0xA5 with ASD=0x50, BSD=0x30 -> o_SND=0x0500 (80<<4).
- Mid-mix interference:
  - During a mix with vol 0xFF, ASD=BSD=0x00: extra i_CEN at cycle 4 and SLEV write 0x00 at cycle 5 -> result still 0x8800, a single o_VALID, o_VOLA/o_VOLB=0 afterwards. The next tick yields 0x0000.
  - Assert i_RST at cycle 6 -> o_SND=0, o_BUSY=0, no o_VALID.
- OUT_W=12, GAIN_SHIFT=4, vol 0xF0, ASD=0x7F -> o_SND=0x7FF with K007232_VOLMIX_SAT_EN, 0xB10 without; ASD=0x00 -> 0x800 with SAT, 0x400 without.
